// File: rtl/uart_tx_port_if.sv
// Data-memory bus slice seen by the UART TX port: CPU store/load strobes in,
// status read data and address hit back out.
interface uart_tx_port_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR fill a byte FIFO that the
// TX FSM drains LSB first; STATUS_ADDR reads {overflow, full, empty, busy, 0}.
module uart_tx_port #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h1001_0400,
  parameter logic [31:0] STATUS_ADDR  = 32'h1001_0404
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  bus,
  output logic           TxD
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_COUNT  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_txd, w_txd_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  logic w_tx_sel, w_st_sel;
  logic w_push_sel, w_accept, w_pop, w_clr;
  logic w_full, w_empty, w_busy, w_bit_end;
  logic w_unused_wdata;

  assign w_tx_sel   = (bus.Address == TX_ADDR);
  assign w_st_sel   = (bus.Address == STATUS_ADDR);
  assign w_push_sel = bus.MemWrite && w_tx_sel;
  assign w_clr      = bus.MemWrite && w_st_sel && bus.WriteData[4];
  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  // A push into a full FIFO still fits when the same edge pops a byte out.
  assign w_accept   = w_push_sel && (!w_full || w_pop);
  assign w_busy     = (r_state != S_IDLE);
  assign w_bit_end  = (r_baud == '0);

  assign w_unused_wdata = ^bus.WriteData[31:8];

  assign bus.Hit      = w_tx_sel || w_st_sel;
  assign bus.ReadData = (bus.MemRead && w_st_sel)
                      ? {27'b0, r_overflow, w_full, w_empty, w_busy, 1'b0}
                      : 32'b0;
  assign TxD = r_txd;

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_clr)                        r_overflow <= 1'b0;
      else if (w_push_sel && !w_accept) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_baud_nxt  = BAUD_RELOAD;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter on the data-memory bus of the single-cycle MIPS processor, downstream of the processor's store path. A `sw` to the TX data address pushes one byte into a small FIFO. The block serializes FIFO bytes as 8N1 frames on `TxD`. A status word read via `lw` lets software poll for FIFO space and detect dropped bytes.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of 2, ≥ 2.
- `TX_ADDR`, 32'h1001_0400: byte address of the TX data register.
- `STATUS_ADDR`, 32'h1001_0404: byte address of the status/control register.
- `clk`  in  1  system clock; one clock domain, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Address`  in  32  byte address from the ALU result.
- `WriteData`  in  32  store data; TX uses bits [7:0].
- `MemWrite`  in  1  store strobe, one cycle per `sw`.
- `MemRead`  in  1  load strobe.
- `ReadData`  out  32  status word, combinational; 0 when not selected.
- `Hit`  out  1  combinational; 1 when `Address` equals `TX_ADDR` or `STATUS_ADDR`. Top level uses it to mux `ReadData` over the data memory.
- `TxD`  out  1  serial output; idles high.

## Operation
- **Push.** A push happens on the edge where `MemWrite`=1 and `Address`==`TX_ADDR`.
  - If the FIFO is not full, `WriteData[7:0]` is enqueued.
  - If the FIFO is full, the byte is dropped and sticky `overflow` is set.
  - Only exact address matches decode; no partial decode.
- **Status word** = {27'b0, `overflow`, `full`, `empty`, `busy`, 1'b0}.
  - bit 4 `overflow`, bit 3 `full`, bit 2 `empty`, bit 1 `busy`.
  - `busy` = FSM not in IDLE.
  - `ReadData` drives the status word when `MemRead`=1 and `Address`==`STATUS_ADDR`; otherwise 0.
- **Clear overflow.** A `MemWrite` to `STATUS_ADDR` with `WriteData[4]`=1 clears `overflow`. If a dropped push and a clear occur on the same edge, clear wins.
- **FIFO.**
  - Circular buffer; read/write pointers of log2(FIFO_DEPTH) bits wrap naturally.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - `full` = count==FIFO_DEPTH; `empty` = count==0.
  - Push and pop on the same edge: count unchanged. This holds when full too: the push is accepted, no overflow.
- **TX FSM** states: IDLE, START, DATA, STOP.
  - Baud counter reloads to `CLKS_PER_BIT`-1 at each bit start and decrements; the bit ends at 0.
  - IDLE: `TxD`=1. If FIFO is not empty, pop into an 8-bit shift register, go to START.
  - START: `TxD`=0 for one bit time, then DATA with bit index 0.
  - DATA: `TxD`=shift[0]. Each bit lasts one bit time, then shift right and increment the index. After bit 7, go to STOP. Transmission is LSB first.
  - STOP: `TxD`=1 for one bit time. At the end, if FIFO is not empty, pop and go directly to START (no idle gap); else go to IDLE.
- `TxD` is a registered output driven from FSM state and shift register.

## Timing
- **Reset values:** `TxD`=1, FSM IDLE, FIFO empty (pointers and count 0), `overflow`=0, status word = 32'h4.
- **Reset mid-frame:** the frame is aborted and `TxD` returns to 1 asynchronously. Queued bytes are discarded.
- **Push to TX latency.** Push at edge N: FIFO becomes non-empty after N. IDLE pops at edge N+1, so `TxD` falls after edge N+1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles (start, 8 data bits, stop).
- **Back-to-back frames.** The next start bit begins on the cycle after the last stop-bit cycle; `busy` stays 1 throughout.
- **Status timing.** Status reflects registered state. A push at edge N is visible in status from the cycle after N.
- **Push while empty and IDLE** on the same edge: the push is accepted and the pop occurs at the following edge. No byte is lost.

## Test plan
- **Reset and idle.** Deassert `reset` and read `STATUS_ADDR`. Required: `ReadData`=32'h4, `TxD`=1, `Hit`=1; `Hit`=0 for address 32'h1001_0000.
- **Single byte** (`CLKS_PER_BIT`=4). `sw` 32'h0000_00A5 to `TX_ADDR`. Required:
  - `TxD` low for 4 cycles starting after edge N+1.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then high; `busy` drops after 40 cycles.
- **Back-to-back.** Push 8'h55, 8'h0F on consecutive cycles. Required: two frames with no gap between the stop bit and the next start bit; 80 total cycles busy.
- **Overflow.** Push 10 bytes in 10 consecutive cycles with `FIFO_DEPTH`=8. Required:
  - The first byte is popped at edge 2, so pushes 1–9 are accepted and push 10 is dropped.
  - Status `overflow`=1 and `full`=1.
  - Writing 32'h10 to `STATUS_ADDR` clears `overflow`.
  - Exactly 9 frames are transmitted, in order.
- **Full push/pop collision.** With the FIFO full at the STOP→START pop edge, push 8'h3C. Required: the push is accepted, `overflow` stays 0, and 8'h3C is transmitted last.
- **Reset mid-frame.** Assert `reset` during DATA bit 3. Required: `TxD`=1 immediately (no clock needed), status 32'h4 after release, and no further frames.
